// File: rtl/banked_sram_pkg.sv
// banked_sram_pkg: address-decode helpers and the deferred-write queue entry type
// shared by the banked SRAM arbiter.
package banked_sram_pkg;
    localparam int QE_BANK_W = 8;
    localparam int QE_WORD_W = 32;
    localparam int QE_DATA_W = 64;

    typedef struct packed {
        logic [QE_BANK_W-1:0] bank;
        logic [QE_WORD_W-1:0] word;
        logic [QE_DATA_W-1:0] data;
    } q_entry_t;

    typedef enum logic [1:0] {RD_ZERO, RD_FWD, RD_BANK} rd_src_e;

    function automatic logic region_match(input logic [63:0] addr, input int awidth, input logic [3:0] region);
        return addr[awidth-4 +: 4] == region;
    endfunction

    // bw==0 masks everything off, so a single-bank build always decodes bank 0
    function automatic logic [QE_BANK_W-1:0] bank_of(input logic [63:0] addr, input int bank_awidth, input int bw);
        return QE_BANK_W'((addr >> bank_awidth) & ((64'd1 << bw) - 64'd1));
    endfunction

    function automatic logic [QE_WORD_W-1:0] word_of(input logic [63:0] addr, input int bank_awidth);
        return QE_WORD_W'(addr & ((64'd1 << bank_awidth) - 64'd1));
    endfunction
endpackage

// File: rtl/banked_sram_arb_bank.sv
// sram_bank: one write port and one registered, enabled read port; a read and a
// write to the same word at one edge return the old word.
module sram_bank #(
    parameter int DWIDTH      = 16,
    parameter int BANK_AWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [BANK_AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0]      i_wdata,
    input  logic                   i_re,
    input  logic [BANK_AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0]      o_rdata
);
    logic [DWIDTH-1:0] r_mem [2**BANK_AWIDTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/banked_sram_arb.sv
// banked_sram_arb: BANKS-bank SRAM with debug-priority write arbitration, an in-order
// deferred CPU write queue for lost bank conflicts, and read forwarding from that queue.
module banked_sram_arb
    import banked_sram_pkg::*;
#(
    parameter int         DWIDTH      = 16,
    parameter int         AWIDTH      = 16,
    parameter logic [3:0] REGION      = 4'h0,
    parameter int         BANKS       = 2,
    parameter int         BANK_AWIDTH = 8,
    parameter int         QDEPTH      = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dbg_we,
    input  logic [AWIDTH-1:0] dbg_waddr,
    input  logic [DWIDTH-1:0] dbg_wdata,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_waddr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_wready,
    input  logic              cpu_re,
    input  logic [AWIDTH-1:0] cpu_raddr,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              wr_ovf
);
    localparam int BW = $clog2(BANKS);
    localparam int QW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [QW-1:0] QLAST = QW'(QDEPTH - 1);

    q_entry_t             r_q [QDEPTH];
    logic [QW-1:0]        r_head, r_tail;
    logic [CW-1:0]        r_count;
    rd_src_e              r_src;
    logic [QE_BANK_W-1:0] r_sel_bank;
    logic [DWIDTH-1:0]    r_fwd_data;

    logic                   w_dbg_ok, w_cpu_in, w_rd_ok, w_pop, w_direct, w_push, w_fwd;
    logic [QE_BANK_W-1:0]   w_dbg_bank, w_cpu_bank, w_rd_bank;
    logic [BANK_AWIDTH-1:0] w_dbg_word, w_cpu_word, w_rd_word;
    logic [QW-1:0]          w_idx;
    q_entry_t               w_head, w_new;
    logic [DWIDTH-1:0]      w_fwd_data, w_sel_rdata;
    logic [DWIDTH-1:0]      w_bank_rdata [BANKS];

    assign w_dbg_ok   = dbg_we & region_match(64'(dbg_waddr), AWIDTH, REGION);
    assign w_dbg_bank = bank_of(64'(dbg_waddr), BANK_AWIDTH, BW);
    assign w_dbg_word = BANK_AWIDTH'(word_of(64'(dbg_waddr), BANK_AWIDTH));
    assign w_cpu_bank = bank_of(64'(cpu_waddr), BANK_AWIDTH, BW);
    assign w_cpu_word = BANK_AWIDTH'(word_of(64'(cpu_waddr), BANK_AWIDTH));
    assign w_rd_ok    = cpu_re & region_match(64'(cpu_raddr), AWIDTH, REGION);
    assign w_rd_bank  = bank_of(64'(cpu_raddr), BANK_AWIDTH, BW);
    assign w_rd_word  = BANK_AWIDTH'(word_of(64'(cpu_raddr), BANK_AWIDTH));

    assign cpu_wready = r_count < CW'(QDEPTH);
    assign w_head     = r_q[r_head];
    assign w_cpu_in   = cpu_we & cpu_wready & region_match(64'(cpu_waddr), AWIDTH, REGION);
    assign w_pop      = (r_count != '0) & ~(w_dbg_ok & (w_dbg_bank == w_head.bank));
    // a CPU write may only bypass the queue when nothing older is waiting
    assign w_direct   = w_cpu_in & (r_count == '0) & ~(w_dbg_ok & (w_dbg_bank == w_cpu_bank));
    assign w_push     = w_cpu_in & ~w_direct;
    assign w_new      = '{bank: w_cpu_bank, word: QE_WORD_W'(w_cpu_word), data: QE_DATA_W'(cpu_wdata)};

    // oldest-to-youngest scan so the youngest match wins; this cycle's push is youngest of all
    always_comb begin
        w_fwd      = 1'b0;
        w_fwd_data = '0;
        w_idx      = r_head;
        for (int k = 0; k < QDEPTH; k++) begin
            w_idx = QW'((int'(r_head) + k) % QDEPTH);
            if (k < int'(r_count) && r_q[w_idx].bank == w_rd_bank && r_q[w_idx].word == QE_WORD_W'(w_rd_word)) begin
                w_fwd      = 1'b1;
                w_fwd_data = DWIDTH'(r_q[w_idx].data);
            end
        end
        if (w_push && w_cpu_bank == w_rd_bank && w_cpu_word == w_rd_word) begin
            w_fwd      = 1'b1;
            w_fwd_data = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_src      <= RD_ZERO;
            r_sel_bank <= '0;
            r_fwd_data <= '0;
            cpu_rvalid <= 1'b0;
            wr_ovf     <= 1'b0;
        end else begin
            if (w_pop) r_head <= r_head == QLAST ? '0 : r_head + QW'(1);
            if (w_push) r_tail <= r_tail == QLAST ? '0 : r_tail + QW'(1);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            wr_ovf     <= wr_ovf | (cpu_we & ~cpu_wready);
            cpu_rvalid <= cpu_re;
            if (cpu_re) begin
                r_src      <= !w_rd_ok ? RD_ZERO : w_fwd ? RD_FWD : RD_BANK;
                r_sel_bank <= w_rd_bank;
                r_fwd_data <= w_fwd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_q[r_tail] <= w_new;
    end

    always_comb begin
        w_sel_rdata = '0;
        for (int k = 0; k < BANKS; k++)
            if (r_sel_bank == QE_BANK_W'(k)) w_sel_rdata = w_bank_rdata[k];
        cpu_rdata = r_src == RD_FWD ? r_fwd_data : r_src == RD_BANK ? w_sel_rdata : '0;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic w_dbg_hit, w_q_hit, w_c_hit;
        assign w_dbg_hit = w_dbg_ok && w_dbg_bank == QE_BANK_W'(b);
        assign w_q_hit   = w_pop && w_head.bank == QE_BANK_W'(b);
        assign w_c_hit   = w_direct && w_cpu_bank == QE_BANK_W'(b);
        sram_bank #(.DWIDTH(DWIDTH), .BANK_AWIDTH(BANK_AWIDTH)) u_bank (
            .clk     (clk),
            .i_we    (w_dbg_hit | w_q_hit | w_c_hit),
            .i_waddr (w_dbg_hit ? w_dbg_word : w_q_hit ? BANK_AWIDTH'(w_head.word) : w_cpu_word),
            .i_wdata (w_dbg_hit ? dbg_wdata : w_q_hit ? DWIDTH'(w_head.data) : cpu_wdata),
            .i_re    (w_rd_ok && w_rd_bank == QE_BANK_W'(b)),
            .i_raddr (w_rd_word),
            .o_rdata (w_bank_rdata[b])
        );
    end
endmodule

// File: tb/tb_banked_sram_arb.sv
// tb_banked_sram_arb: directed vector table plus hand-written overflow and reset-mid-queue
// sequences for banked_sram_arb with default parameters.
module tb_banked_sram_arb;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dbg_we = 1'b0, cpu_we = 1'b0, cpu_re = 1'b0;
    logic [15:0] dbg_waddr = '0, dbg_wdata = '0, cpu_waddr = '0, cpu_wdata = '0, cpu_raddr = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_wready, cpu_rvalid, wr_ovf;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        dwe;
        logic [15:0] da, dd;
        logic        cwe;
        logic [15:0] ca, cd;
        logic        re;
        logic [15:0] ra;
        logic        ewr, erv;
        logic [15:0] erd;
        logic        eovf;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    banked_sram_arb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dbg_we     (dbg_we),
        .dbg_waddr  (dbg_waddr),
        .dbg_wdata  (dbg_wdata),
        .cpu_we     (cpu_we),
        .cpu_waddr  (cpu_waddr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wready (cpu_wready),
        .cpu_re     (cpu_re),
        .cpu_raddr  (cpu_raddr),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .wr_ovf     (wr_ovf)
    );

    function automatic vec_t mk(input logic dwe, input logic [15:0] da, dd, input logic cwe,
                                input logic [15:0] ca, cd, input logic re, input logic [15:0] ra,
                                input logic ewr, erv, input logic [15:0] erd, input logic eovf);
        return '{dwe, da, dd, cwe, ca, cd, re, ra, ewr, erv, erd, eovf};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic ewr, erv, input logic [15:0] erd, input logic eovf);
        chk({nm, ".wready"}, 16'(cpu_wready), 16'(ewr));
        chk({nm, ".rvalid"}, 16'(cpu_rvalid), 16'(erv));
        chk({nm, ".rdata"}, cpu_rdata, erd);
        chk({nm, ".wr_ovf"}, 16'(wr_ovf), 16'(eovf));
    endtask

    // drive one cycle's inputs at the falling edge and check outputs left by earlier edges
    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        dbg_we = v.dwe; dbg_waddr = v.da; dbg_wdata = v.dd;
        cpu_we = v.cwe; cpu_waddr = v.ca; cpu_wdata = v.cd;
        cpu_re = v.re;  cpu_raddr = v.ra;
        #1;
        check_outs(nm, v.ewr, v.erv, v.erd, v.eovf);
    endtask

    initial begin
        //        dwe  da       dd       cwe  ca       cd       re   ra       wr rv rdata    ovf
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0005, 16'hBEEF, 0, 16'h0000, 1, 0, 16'h0000, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0005, 1, 0, 16'h0000, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'hBEEF, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'hBEEF, 0));
        tv.push_back(mk(1, 16'h0010, 16'h1111, 1, 16'h0020, 16'h2222, 1, 16'h0020, 1, 0, 16'hBEEF, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0010, 1, 1, 16'h2222, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0020, 1, 1, 16'h1111, 0));
        tv.push_back(mk(1, 16'h0010, 16'hAAAA, 1, 16'h0110, 16'h5555, 0, 16'h0000, 1, 1, 16'h2222, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0010, 1, 0, 16'h2222, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0110, 1, 1, 16'hAAAA, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h8005, 1, 1, 16'h5555, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0205, 1, 1, 16'h0000, 0));
        tv.push_back(mk(1, 16'hF005, 16'hDEAD, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'hBEEF, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0005, 1, 0, 16'hBEEF, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0030, 16'h3333, 0, 16'h0000, 1, 1, 16'hBEEF, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0030, 16'h4444, 1, 16'h0030, 1, 0, 16'hBEEF, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0030, 1, 1, 16'h3333, 0));
        tv.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h4444, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tv[i]) step(tv[i], $sformatf("v%0d", i));

        // queue fill and overflow: debug holds bank 0 while the CPU keeps writing word 0x50
        step(mk(1, 16'h0040, 16'hD000, 1, 16'h0050, 16'h0001, 0, 16'h0000, 1, 0, 16'h4444, 0), "ovf1");
        step(mk(1, 16'h0041, 16'hD001, 1, 16'h0050, 16'h0002, 0, 16'h0000, 1, 0, 16'h4444, 0), "ovf2");
        step(mk(1, 16'h0042, 16'hD002, 1, 16'h0050, 16'h0003, 0, 16'h0000, 0, 0, 16'h4444, 0), "ovf3");
        step(mk(1, 16'h0043, 16'hD003, 1, 16'h0050, 16'h0004, 1, 16'h0050, 0, 0, 16'h4444, 1), "ovf4");
        step(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 16'h0002, 1), "ovf5");
        step(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0043, 1, 0, 16'h0002, 1), "ovf6");
        step(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0050, 1, 1, 16'hD003, 1), "ovf7");
        step(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0002, 1), "ovf8");

        // reset with two entries queued: the queued words must never reach memory
        step(mk(0, 16'h0000, 16'h0000, 1, 16'h0070, 16'h1234, 0, 16'h0000, 1, 0, 16'h0002, 1), "rst1");
        step(mk(0, 16'h0000, 16'h0000, 1, 16'h0071, 16'h5678, 0, 16'h0000, 1, 0, 16'h0002, 1), "rst2");
        step(mk(1, 16'h0060, 16'hE000, 1, 16'h0070, 16'h7777, 0, 16'h0000, 1, 0, 16'h0002, 1), "rst3");
        step(mk(1, 16'h0061, 16'hE001, 1, 16'h0071, 16'h7171, 0, 16'h0000, 1, 0, 16'h0002, 1), "rst4");
        @(negedge clk);
        dbg_we = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
        #1 chk("rst_pre.wready", 16'(cpu_wready), 16'h0000);
        reset_n = 1'b0;
        #1 check_outs("rst_async", 1, 0, 16'h0000, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0070, 1, 0, 16'h0000, 0), "rst5");
        step(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0071, 1, 1, 16'h1234, 0), "rst6");
        step(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h5678, 0), "rst7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
